// File: rtl/bits_operand_join.sv
// ============================================================================
//  Module   : bits_operand_join
//  Purpose  : Joins two independent valid/ready operand streams into one
//             registered operand-pair stream for the 3-bit bitwise unit,
//             with a wrapping count of pairs handed downstream.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bits_operand_join #(
    parameter int WIDTH     = 3,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [WIDTH-1:0]     I0,
    input  logic                 I0_valid,
    output logic                 I0_ready,
    input  logic [WIDTH-1:0]     I1,
    input  logic                 I1_valid,
    output logic                 I1_ready,
    output logic [WIDTH-1:0]     O0,
    output logic [WIDTH-1:0]     O1,
    output logic                 O_valid,
    input  logic                 O_ready,
    output logic [CNT_WIDTH-1:0] PAIR_COUNT
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    logic [WIDTH-1:0]     r_h0;
    logic [WIDTH-1:0]     r_h1;
    logic                 r_h0_v;
    logic                 r_h1_v;
    logic [WIDTH-1:0]     r_o0;
    logic [WIDTH-1:0]     r_o1;
    logic                 r_o_valid;
    logic [CNT_WIDTH-1:0] r_pair_count;

    logic                 w_join;
    logic                 w_take0;
    logic                 w_take1;
    logic                 w_handoff;

    // A pair moves into the output register whenever both holds are full and
    // the output slot is empty or draining this cycle.
    assign w_join    = r_h0_v && r_h1_v && (!r_o_valid || O_ready);
    assign w_handoff = r_o_valid && O_ready;

    // A departing operand frees its hold in the same cycle, so ready can
    // follow O_ready combinationally and sustain one pair per cycle.
    assign I0_ready  = !r_h0_v || w_join;
    assign I1_ready  = !r_h1_v || w_join;
    assign w_take0   = I0_valid && I0_ready;
    assign w_take1   = I1_valid && I1_ready;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_h0         <= '0;
            r_h1         <= '0;
            r_h0_v       <= 1'b0;
            r_h1_v       <= 1'b0;
            r_o0         <= '0;
            r_o1         <= '0;
            r_o_valid    <= 1'b0;
            r_pair_count <= '0;
        end else begin
            if (w_take0) begin
                r_h0   <= I0;
                r_h0_v <= 1'b1;
            end else if (w_join) begin
                r_h0_v <= 1'b0;
            end

            if (w_take1) begin
                r_h1   <= I1;
                r_h1_v <= 1'b1;
            end else if (w_join) begin
                r_h1_v <= 1'b0;
            end

            if (w_join) begin
                r_o0      <= r_h0;
                r_o1      <= r_h1;
                r_o_valid <= 1'b1;
            end else if (w_handoff) begin
                r_o_valid <= 1'b0;
            end

            // Wraps silently at the top of the range.
            if (w_handoff) begin
                r_pair_count <= r_pair_count + c_cnt_one;
            end
        end
    end

    assign O0         = r_o0;
    assign O1         = r_o1;
    assign O_valid    = r_o_valid;
    assign PAIR_COUNT = r_pair_count;

endmodule

`default_nettype wire

// File: tb/tb_bits_operand_join.sv
// ============================================================================
//  Module   : tb_bits_operand_join
//  Purpose  : Self-checking bench for bits_operand_join (directed vectors,
//             skew, backpressure, wrap, mid-op reset and random traffic).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bits_operand_join;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
    } pair_t;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] e0;
        logic [2:0] e1;
        logic [2:0] eand;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [2:0] I0, I1;
    logic       I0_valid, I1_valid, O_ready;
    wire        I0_ready, I1_ready, O_valid;
    wire  [2:0] O0, O1;
    wire  [7:0] pc8;
    wire        r0_3, r1_3, ov_3;
    wire  [2:0] o0_3, o1_3, pc3;

    always #5 CLK = ~CLK;

    bits_operand_join #(.WIDTH(3), .CNT_WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .I0(I0), .I0_valid(I0_valid), .I0_ready(I0_ready),
        .I1(I1), .I1_valid(I1_valid), .I1_ready(I1_ready),
        .O0(O0), .O1(O1), .O_valid(O_valid), .O_ready(O_ready),
        .PAIR_COUNT(pc8)
    );

    bits_operand_join #(.WIDTH(3), .CNT_WIDTH(3)) dut_c3 (
        .CLK(CLK), .RESET(RESET),
        .I0(I0), .I0_valid(I0_valid), .I0_ready(r0_3),
        .I1(I1), .I1_valid(I1_valid), .I1_ready(r1_3),
        .O0(o0_3), .O1(o1_3), .O_valid(ov_3), .O_ready(O_ready),
        .PAIR_COUNT(pc3)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cc = 0;
    logic [2:0] q0[$], q1[$], src0[$], src1[$];
    pair_t      expq[$], seen[$];
    int         hcyc[$];
    int         acc0, acc1, hand, held0, held1;
    bit         jm, prev_stall;
    logic [2:0] prev_o0, prev_o1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial forever begin
        @(posedge CLK);
        cc++;
    end

    // Transaction-level reference: accepted operands are queued per stream,
    // zipped in arrival order, and each output handoff must match the oldest pair.
    initial forever begin
        @(negedge CLK);
        if (RESET) begin
            q0.delete(); q1.delete(); expq.delete();
            acc0 = 0; acc1 = 0; hand = 0; prev_stall = 0;
        end else begin
            held0 = acc0 - hand - int'(O_valid);
            held1 = acc1 - hand - int'(O_valid);
            chk("held0_range", 32'(held0 >= 0 && held0 <= 1), 1);
            chk("held1_range", 32'(held1 >= 0 && held1 <= 1), 1);
            jm = (held0 == 1) && (held1 == 1) && (!O_valid || O_ready);
            chk("i0_ready", 32'(I0_ready), 32'((held0 == 0) || jm));
            chk("i1_ready", 32'(I1_ready), 32'((held1 == 0) || jm));
            chk("i0_ready_c3", 32'(r0_3), 32'((held0 == 0) || jm));
            chk("pair_count8", 32'(pc8), 32'(hand % 256));
            chk("pair_count3", 32'(pc3), 32'(hand % 8));
            if (prev_stall) begin
                chk("o_valid_held", 32'(O_valid), 1);
                chk("o0_stable", 32'(O0), 32'(prev_o0));
                chk("o1_stable", 32'(O1), 32'(prev_o1));
            end
            if (O_valid) begin
                chk("o_valid_has_pair", 32'(expq.size() > 0), 1);
                if (O_ready && expq.size() > 0) begin
                    chk("o0_order", 32'(O0), 32'(expq[0].a));
                    chk("o1_order", 32'(O1), 32'(expq[0].b));
                    chk("o0_order_c3", 32'(o0_3), 32'(expq[0].a));
                    chk("o_valid_c3", 32'(ov_3), 1);
                    seen.push_back(pair_t'{a: O0, b: O1});
                    hcyc.push_back(cc);
                    void'(expq.pop_front());
                end
            end
            if (O_valid && O_ready) hand++;
            prev_stall = O_valid && !O_ready;
            prev_o0 = O0;
            prev_o1 = O1;
            if (I0_valid && I0_ready) begin q0.push_back(I0); acc0++; end
            if (I1_valid && I1_ready) begin q1.push_back(I1); acc1++; end
            while (q0.size() > 0 && q1.size() > 0)
                expq.push_back(pair_t'{a: q0.pop_front(), b: q1.pop_front()});
        end
    end

    task automatic reset_dut();
        RESET = 1'b1; I0_valid = 1'b0; I1_valid = 1'b0; O_ready = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    // omode: 0 = always ready, 1 = toggle each cycle, 2 = random.
    task automatic run(input int delay1, input int omode, input bit rvalid, input int budget);
        int cyc, target;
        bit t0, t1, pend0, pend1;
        target = seen.size() + ((src0.size() < src1.size()) ? src0.size() : src1.size());
        cyc = 0; pend0 = 0; pend1 = 0;
        while ((src0.size() > 0 || src1.size() > 0 || seen.size() < target) && cyc < budget) begin
            I0_valid = (src0.size() > 0) && (pend0 || !rvalid || ($urandom_range(3) != 0));
            I0       = (src0.size() > 0) ? src0[0] : 3'd0;
            I1_valid = (cyc >= delay1) && (src1.size() > 0) &&
                       (pend1 || !rvalid || ($urandom_range(3) != 0));
            I1       = (src1.size() > 0) ? src1[0] : 3'd0;
            case (omode)
                0:       O_ready = 1'b1;
                1:       O_ready = (cyc % 2 == 0);
                default: O_ready = 1'($urandom_range(1));
            endcase
            @(negedge CLK);
            t0 = I0_valid && I0_ready;
            t1 = I1_valid && I1_ready;
            if (delay1 > 0 && cyc >= 1 && cyc < delay1)
                chk("skew_i0_ready", 32'(I0_ready), 0);
            tick();
            pend0 = I0_valid && !t0;
            pend1 = I1_valid && !t1;
            if (t0) void'(src0.pop_front());
            if (t1) void'(src1.pop_front());
            cyc++;
        end
        chk("pairs_delivered", 32'(seen.size()), 32'(target));
        I0_valid = 1'b0; I1_valid = 1'b0; O_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        vec_t  vecs[5];
        pair_t exp3[3];
        int    s, h0, st;

        vecs[0] = '{a: 3'b101, b: 3'b011, e0: 3'b101, e1: 3'b011, eand: 3'b001};
        vecs[1] = '{a: 3'b111, b: 3'b111, e0: 3'b111, e1: 3'b111, eand: 3'b111};
        vecs[2] = '{a: 3'b000, b: 3'b111, e0: 3'b000, e1: 3'b111, eand: 3'b000};
        vecs[3] = '{a: 3'b110, b: 3'b011, e0: 3'b110, e1: 3'b011, eand: 3'b010};
        vecs[4] = '{a: 3'b100, b: 3'b101, e0: 3'b100, e1: 3'b101, eand: 3'b100};
        exp3[0] = '{a: 3'd1, b: 3'd4};
        exp3[1] = '{a: 3'd2, b: 3'd5};
        exp3[2] = '{a: 3'd3, b: 3'd6};

        // Reset held two cycles with valids high.
        RESET = 1'b1; I0 = 3'd7; I1 = 3'd7; I0_valid = 1'b1; I1_valid = 1'b1; O_ready = 1'b1;
        tick(); tick();
        RESET = 1'b0; I0_valid = 1'b0; I1_valid = 1'b0;
        @(negedge CLK);
        chk("rst_o_valid", 32'(O_valid), 0);
        chk("rst_count", 32'(pc8), 0);
        chk("rst_i0_ready", 32'(I0_ready), 1);
        chk("rst_i1_ready", 32'(I1_ready), 1);
        chk("rst_o0", 32'(O0), 0);
        tick();

        // Single pairs, two-edge latency.
        for (int i = 0; i < 5; i++) begin
            I0 = vecs[i].a; I1 = vecs[i].b; I0_valid = 1'b1; I1_valid = 1'b1; O_ready = 1'b1;
            tick();
            I0_valid = 1'b0; I1_valid = 1'b0;
            @(negedge CLK);
            chk("lat_not_early", 32'(O_valid), 0);
            tick();
            @(negedge CLK);
            chk("lat_o_valid", 32'(O_valid), 1);
            chk("vec_o0", 32'(O0), 32'(vecs[i].e0));
            chk("vec_o1", 32'(O1), 32'(vecs[i].e1));
            chk("vec_and", 32'(O0 & O1), 32'(vecs[i].eand));
            tick();
            @(negedge CLK);
            chk("vec_count", 32'(pc8), 32'(i + 1));
            chk("vec_drained", 32'(O_valid), 0);
            tick();
        end

        // Skew: I0 runs ahead, I1 arrives after four idle cycles.
        reset_dut();
        src0 = '{3'd1, 3'd2, 3'd3};
        src1 = '{3'd4, 3'd5, 3'd6};
        s = seen.size();
        run(4, 0, 1'b0, 100);
        for (int k = 0; k < 3; k++)
            chk("skew_order", 32'(seen[s + k]), 32'(exp3[k]));

        // Backpressure: O_ready toggles every cycle.
        reset_dut();
        for (int k = 0; k < 8; k++) begin
            src0.push_back(3'(k));
            src1.push_back(3'(7 - k));
        end
        s = seen.size();
        run(0, 1, 1'b0, 200);
        @(negedge CLK);
        chk("bp_count", 32'(pc8), 8);
        chk("bp_pairs", 32'(seen.size() - s), 8);
        tick();

        // Throughput and 3-bit counter wrap.
        reset_dut();
        for (int k = 0; k < 9; k++) begin
            src0.push_back(3'(k));
            src1.push_back(3'(k + 3));
        end
        h0 = hcyc.size();
        st = cc;
        run(0, 0, 1'b0, 100);
        @(negedge CLK);
        chk("tp_fill", 32'(hcyc[h0] - st), 2);
        chk("tp_span", 32'(hcyc[hcyc.size() - 1] - hcyc[h0]), 8);
        chk("wrap_count3", 32'(pc3), 1);
        chk("wrap_count8", 32'(pc8), 9);
        tick();

        // Mid-operation reset with a held I0 and a stalled pair.
        reset_dut();
        O_ready = 1'b0;
        I0 = 3'd1; I1 = 3'd2; I0_valid = 1'b1; I1_valid = 1'b1;
        tick();
        I0 = 3'd3; I1_valid = 1'b0;
        tick();
        I0_valid = 1'b0;
        @(negedge CLK);
        chk("mid_o_valid", 32'(O_valid), 1);
        chk("mid_o0", 32'(O0), 1);
        chk("mid_o1", 32'(O1), 2);
        chk("mid_i0_blocked", 32'(I0_ready), 0);
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        chk("mrst_o_valid", 32'(O_valid), 0);
        chk("mrst_i0_ready", 32'(I0_ready), 1);
        chk("mrst_i1_ready", 32'(I1_ready), 1);
        chk("mrst_count", 32'(pc8), 0);
        tick();
        src0 = '{3'd6};
        src1 = '{3'd7};
        s = seen.size();
        run(0, 0, 1'b0, 50);
        chk("mrst_one_pair", 32'(seen.size() - s), 1);
        chk("mrst_pair", 32'(seen[seen.size() - 1]), 32'(pair_t'{a: 3'd6, b: 3'd7}));

        // Random traffic with random valids and backpressure.
        reset_dut();
        for (int k = 0; k < 24; k++) begin
            src0.push_back(3'($urandom_range(7)));
            src1.push_back(3'($urandom_range(7)));
        end
        run(0, 2, 1'b1, 2000);
        @(negedge CLK);
        chk("rand_count", 32'(pc8), 24);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
